// File: rtl/i2s_sample_buffer_if.sv
// rtl/i2s_sample_buffer_if.sv - sample-pair handshake and transmitter read port bundle
interface i2s_sample_buffer_if #(
  parameter int DW    = 24,
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_left;
  logic [DW-1:0] s_right;
  logic          rd_en;
  logic          o_valid;
  logic [DW-1:0] l_sample;
  logic [DW-1:0] r_sample;
  logic [LW-1:0] level;
  logic          underrun;
  logic [15:0]   underrun_cnt;
  logic          clr_stats;

  modport master (
    output s_valid, s_left, s_right, rd_en, clr_stats,
    input  s_ready, o_valid, l_sample, r_sample, level, underrun, underrun_cnt
  );

  modport slave (
    input  s_valid, s_left, s_right, rd_en, clr_stats,
    output s_ready, o_valid, l_sample, r_sample, level, underrun, underrun_cnt
  );
endinterface

// File: rtl/i2s_sample_buffer.sv
// rtl/i2s_sample_buffer.sv - stereo elastic buffer feeding the I2S transmitter
module i2s_sample_buffer #(
  parameter int DW            = 24,
  parameter int DEPTH         = 8,
  parameter int UNDERRUN_HOLD = 0
) (
  input logic               clk,
  input logic               rst_n,
  i2s_sample_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [2*DW-1:0] mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [LW-1:0]   level_q;
  logic [2*DW-1:0] data_q;
  logic [2*DW-1:0] hold_q;
  logic            valid_q;
  logic            urun_q;
  logic [15:0]     cnt_q;
  logic            wr_fire;
  logic            rd_fire;
  logic            rd_empty;

  // Readiness depends only on the stored level, so a read never opens a slot at full.
  assign bus.s_ready = (level_q != FULL);
  assign wr_fire     = bus.s_valid && (level_q != FULL);
  assign rd_fire     = bus.rd_en && (level_q != '0);
  assign rd_empty    = bus.rd_en && (level_q == '0);

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr[AW-1:0]] <= {bus.s_left, bus.s_right};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      data_q  <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      urun_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
        data_q <= mem[rd_ptr[AW-1:0]];
        hold_q <= mem[rd_ptr[AW-1:0]];
      end else if (rd_empty) begin
        data_q <= (UNDERRUN_HOLD != 0) ? hold_q : '0;
      end
      case ({wr_fire, rd_fire})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      valid_q <= bus.rd_en;
      urun_q  <= rd_empty;
      if (bus.clr_stats) begin
        cnt_q <= '0;
      end else if (rd_empty && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign bus.o_valid      = valid_q;
  assign bus.l_sample     = data_q[2*DW-1:DW];
  assign bus.r_sample     = data_q[DW-1:0];
  assign bus.level        = level_q;
  assign bus.underrun     = urun_q;
  assign bus.underrun_cnt = cnt_q;
endmodule

// File: tb/tb_i2s_sample_buffer.sv
// tb/tb_i2s_sample_buffer.sv - randomized and directed checks of both underrun modes against a queue model
module tb_i2s_sample_buffer;
  localparam int DW    = 24;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic [DW-1:0] s_left;
  logic [DW-1:0] s_right;
  logic          rd_en;
  logic          clr_stats;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  i2s_sample_buffer_if #(.DW(DW), .DEPTH(DEPTH)) if0 ();
  i2s_sample_buffer_if #(.DW(DW), .DEPTH(DEPTH)) if1 ();

  assign if0.s_valid = s_valid;   assign if1.s_valid = s_valid;
  assign if0.s_left  = s_left;    assign if1.s_left  = s_left;
  assign if0.s_right = s_right;   assign if1.s_right = s_right;
  assign if0.rd_en   = rd_en;     assign if1.rd_en   = rd_en;
  assign if0.clr_stats = clr_stats;
  assign if1.clr_stats = clr_stats;

  i2s_sample_buffer #(.DW(DW), .DEPTH(DEPTH), .UNDERRUN_HOLD(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  i2s_sample_buffer #(.DW(DW), .DEPTH(DEPTH), .UNDERRUN_HOLD(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  // Reference: a FIFO of pairs plus the last delivered pair.
  logic [2*DW-1:0] q[$];
  logic [2*DW-1:0] m_hold;
  logic [2*DW-1:0] m_d0;
  logic [2*DW-1:0] m_d1;
  logic [2*DW-1:0] m_pair;
  logic            m_ov;
  logic            m_ur;
  logic            m_wr;
  int              m_cnt;
  bit              chk_en = 1'b0;

  task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_hold = '0; m_d0 = '0; m_d1 = '0;
      m_ov = 1'b0; m_ur = 1'b0; m_cnt = 0;
      chk_en = 1'b1;
    end else begin
      m_wr = s_valid && (q.size() != DEPTH);
      m_ov = rd_en;
      m_ur = 1'b0;
      if (rd_en) begin
        if (q.size() > 0) begin
          m_pair = q.pop_front();
          m_hold = m_pair; m_d0 = m_pair; m_d1 = m_pair;
        end else begin
          m_ur = 1'b1;
          m_d0 = '0;
          m_d1 = m_hold;
        end
      end
      if (m_wr) q.push_back({s_left, s_right});
      if (clr_stats) m_cnt = 0;
      else if (m_ur && m_cnt < 16'hFFFF) m_cnt = m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("s_ready0",  if0.s_ready, q.size() != DEPTH);
      check("s_ready1",  if1.s_ready, q.size() != DEPTH);
      check("level0",    if0.level, q.size());
      check("level1",    if1.level, q.size());
      check("o_valid0",  if0.o_valid, m_ov);
      check("o_valid1",  if1.o_valid, m_ov);
      check("underrun0", if0.underrun, m_ur);
      check("underrun1", if1.underrun, m_ur);
      check("cnt0",      if0.underrun_cnt, m_cnt);
      check("cnt1",      if1.underrun_cnt, m_cnt);
      check("data0",     {if0.l_sample, if0.r_sample}, m_d0);
      check("data1",     {if1.l_sample, if1.r_sample}, m_d1);
    end
  end

  task automatic cyc(input logic sv, input logic [DW-1:0] l, input logic [DW-1:0] r,
                     input logic rd, input logic clr);
    s_valid = sv; s_left = l; s_right = r; rd_en = rd; clr_stats = clr;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    s_valid = 1'b0; s_left = '0; s_right = '0; rd_en = 1'b0; clr_stats = 1'b0;
    idle();
    idle();
    rst_n = 1'b1;
    check("lit_reset_level", if0.level, 0);
    check("lit_reset_ready", if0.s_ready, 1);
    check("lit_reset_ovalid", if0.o_valid, 0);

    for (int i = 1; i <= 3; i++) cyc(1'b1, DW'(i), 24'h800000 + DW'(i), 1'b0, 1'b0);
    idle();
    check("lit_three_level", if0.level, 3);
    check("lit_three_ready", if0.s_ready, 1);
    check("lit_three_ovalid", if0.o_valid, 0);

    for (int k = 1; k <= 3; k++) begin
      cyc(1'b0, '0, '0, 1'b1, 1'b0);
      check("lit_read_ovalid", if0.o_valid, 1);
      check("lit_read_l", if0.l_sample, k);
      check("lit_read_r", if0.r_sample, 24'h800000 + k);
      check("lit_read_urun", if0.underrun, 0);
      for (int w = 0; w < 19; w++) idle();
    end
    check("lit_drained_level", if0.level, 0);

    for (int i = 0; i < 10; i++) cyc(1'b1, 24'h000100 + DW'(i), 24'h000900 + DW'(i), 1'b0, 1'b0);
    check("lit_full_level", if0.level, 8);
    check("lit_full_ready", if0.s_ready, 0);
    cyc(1'b1, 24'h000777, 24'h000777, 1'b1, 1'b0);
    check("lit_full_rd_level", if0.level, 7);
    check("lit_full_rd_ready", if0.s_ready, 1);
    check("lit_full_rd_l", if0.l_sample, 24'h000100);
    for (int i = 0; i < 7; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
    check("lit_full_last_l", if0.l_sample, 24'h000107);
    check("lit_full_empty", if0.level, 0);

    cyc(1'b1, 24'hABCDEF, 24'h123456, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    check("lit_hold_src", if1.l_sample, 24'hABCDEF);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    check("lit_urun_zero_l", if0.l_sample, 0);
    check("lit_urun_hold_l", if1.l_sample, 24'hABCDEF);
    check("lit_urun_pulse", if0.underrun, 1);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    check("lit_urun_hold_r", if1.r_sample, 24'h123456);
    check("lit_urun_cnt2", if0.underrun_cnt, 2);

    cyc(1'b1, 24'h5A5A5A, 24'hA5A5A5, 1'b1, 1'b0);
    check("lit_simul_urun", if0.underrun, 1);
    check("lit_simul_level", if0.level, 1);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    check("lit_simul_l", if0.l_sample, 24'h5A5A5A);
    check("lit_simul_nourun", if0.underrun, 0);

    for (int i = 0; i < 5; i++) cyc(1'b1, DW'($urandom), DW'($urandom), 1'b0, 1'b0);
    check("lit_pre_rst_level", if0.level, 5);
    rst_n = 1'b0;
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    rst_n = 1'b1;
    check("lit_rst_ovalid", if0.o_valid, 0);
    check("lit_rst_level", if0.level, 0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    check("lit_rst_urun", if0.underrun, 1);
    check("lit_rst_data", if1.l_sample, 0);

    for (int seg = 0; seg < 3; seg++) begin
      for (int i = 0; i < 1000; i++) begin
        int pw;
        int pr;
        pw = (seg == 0) ? 80 : (seg == 1) ? 20 : 50;
        pr = (seg == 0) ? 20 : (seg == 1) ? 80 : 50;
        cyc($urandom_range(0, 99) < pw, DW'($urandom), DW'($urandom),
            $urandom_range(0, 99) < pr, $urandom_range(0, 99) < 2);
      end
    end

    do_reset();
    for (int i = 0; i < 65534; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
    check("lit_sat_fffe", if0.underrun_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
    check("lit_sat_ffff", if0.underrun_cnt, 16'hFFFF);
    cyc(1'b0, '0, '0, 1'b1, 1'b1);
    check("lit_clr_cnt", if0.underrun_cnt, 0);
    check("lit_clr_pulse", if0.underrun, 1);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
